// File: rtl/dm_arb_pkg.sv
`default_nettype none
// ==== dm_arb_pkg : shared state encoding, master ids and read-tag type for dm_arbiter ==== rev 1.0
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic MST0 = 1'b0;
  localparam logic MST1 = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/dm_arb_if.sv
`default_nettype none
// ==== dm_arb_if : two request ports plus the shared memory issue/return port ==== rev 1.0
interface dm_arb_if;

  logic        m0_req;
  logic        m0_lock;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_byteen;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_lock;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_byteen;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;

  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_rdata;

  // arbiter side
  modport slave (
    input  m0_req, m0_lock, m0_addr, m0_wdata, m0_byteen,
    input  m1_req, m1_lock, m1_addr, m1_wdata, m1_byteen,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_en, mem_addr, mem_wdata, mem_byteen
  );

  // requesters and memory model side
  modport master (
    output m0_req, m0_lock, m0_addr, m0_wdata, m0_byteen,
    output m1_req, m1_lock, m1_addr, m1_wdata, m1_byteen,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_en, mem_addr, mem_wdata, mem_byteen
  );

endinterface
`default_nettype wire

// File: rtl/dm_arb_rdtag.sv
`default_nettype none
// ==== dm_arb_rdtag : RD_LAT-deep {valid, owner} delay line for read returns ==== rev 1.0
module dm_arb_rdtag
  import dm_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t pipe [RD_LAT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ==== dm_arbiter : two-master DM/TC port arbiter with bus lock and tagged read return ==== rev 1.0
// Define DM_ARB_STATS_EN to add the stat_gnt0/stat_gnt1/stat_stall1 counters.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 8
) (
  input  logic        clk,
  input  logic        reset,
  dm_arb_if.slave     bus
`ifdef DM_ARB_STATS_EN
  ,
  output logic [31:0] stat_gnt0,
  output logic [31:0] stat_gnt1,
  output logic [31:0] stat_stall1
`endif
);

  localparam int               CNT_W   = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_e       state, state_nxt;
  logic             rr_ptr, rr_nxt;
  logic [CNT_W-1:0] lock_cnt, cnt_nxt;
  logic             gnt_any, gnt_sel;
  logic             own, own_req, own_lock, oth_req;
  logic             gnt0, gnt1;
  rd_tag_t          tag_in, tag_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= MST0;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      lock_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    cnt_nxt   = lock_cnt;
    gnt_any   = 1'b0;
    gnt_sel   = MST0;
    own       = (state == OWN1);
    own_req   = own ? bus.m1_req  : bus.m0_req;
    own_lock  = own ? bus.m1_lock : bus.m0_lock;
    oth_req   = own ? bus.m0_req  : bus.m1_req;
    case (state)
      OWN0, OWN1: begin
        // Forced hand-over spends one ungranted cycle; the waiter then wins in IDLE.
        if (lock_cnt == CNT_MAX && oth_req) begin
          state_nxt = IDLE;
          rr_nxt    = ~own;
          cnt_nxt   = '0;
        end else if (!own_req) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          gnt_any = 1'b1;
          gnt_sel = own;
          if (!own_lock) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (lock_cnt != CNT_MAX) begin
            cnt_nxt = lock_cnt + CNT_ONE;
          end
        end
      end
      default: begin
        if (bus.m0_req && bus.m1_req) begin
          gnt_any = 1'b1;
          gnt_sel = rr_ptr;
          rr_nxt  = ~rr_ptr;
        end else if (bus.m0_req) begin
          gnt_any = 1'b1;
          gnt_sel = MST0;
        end else if (bus.m1_req) begin
          gnt_any = 1'b1;
          gnt_sel = MST1;
        end
        if (gnt_any && (gnt_sel ? bus.m1_lock : bus.m0_lock)) begin
          state_nxt = gnt_sel ? OWN1 : OWN0;
          cnt_nxt   = CNT_ONE;
        end
      end
    endcase
  end

  // Grants are masked during reset so every output reads 0 immediately.
  assign gnt0 = reset & gnt_any & (gnt_sel == MST0);
  assign gnt1 = reset & gnt_any & (gnt_sel == MST1);

  assign bus.m0_gnt     = gnt0;
  assign bus.m1_gnt     = gnt1;
  assign bus.mem_en     = gnt0 | gnt1;
  assign bus.mem_addr   = gnt0 ? bus.m0_addr   : (gnt1 ? bus.m1_addr   : 32'h0);
  assign bus.mem_wdata  = gnt0 ? bus.m0_wdata  : (gnt1 ? bus.m1_wdata  : 32'h0);
  assign bus.mem_byteen = gnt0 ? bus.m0_byteen : (gnt1 ? bus.m1_byteen : 4'h0);

  assign tag_in.valid = (gnt0 && bus.m0_byteen == 4'h0) || (gnt1 && bus.m1_byteen == 4'h0);
  assign tag_in.owner = gnt1 ? MST1 : MST0;

  dm_arb_rdtag #(
    .RD_LAT (RD_LAT)
  ) u_rdtag (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign bus.m0_rvalid = tag_out.valid && (tag_out.owner == MST0);
  assign bus.m1_rvalid = tag_out.valid && (tag_out.owner == MST1);
  assign bus.m0_rdata  = bus.m0_rvalid ? bus.mem_rdata : 32'h0;
  assign bus.m1_rdata  = bus.m1_rvalid ? bus.mem_rdata : 32'h0;

`ifdef DM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_gnt0   <= '0;
      stat_gnt1   <= '0;
      stat_stall1 <= '0;
    end else begin
      stat_gnt0   <= stat_gnt0 + 32'(gnt0);
      stat_gnt1   <= stat_gnt1 + 32'(gnt1);
      stat_stall1 <= stat_stall1 + 32'(bus.m1_req & ~gnt1);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ==== tb_dm_arbiter : directed scoreboard bench for dm_arbiter (optionally with DM_ARB_STATS_EN) ==== rev 1.0
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  localparam int RD_LAT   = 1;
  localparam int MAX_LOCK = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_arb_if bus ();

`ifdef DM_ARB_STATS_EN
  logic [31:0] stat_gnt0, stat_gnt1, stat_stall1;
`endif

  dm_arbiter #(
    .RD_LAT   (RD_LAT),
    .MAX_LOCK (MAX_LOCK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DM_ARB_STATS_EN
    ,
    .stat_gnt0   (stat_gnt0),
    .stat_gnt1   (stat_gnt1),
    .stat_stall1 (stat_stall1)
`endif
  );

  typedef struct {
    int          cyc;
    logic        mst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } iss_t;

  typedef struct {
    int          cyc;
    logic        mst;
    logic [31:0] data;
  } rd_t;

  iss_t iss_q[$];
  rd_t  rd_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic lock, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    bus.m0_req = req; bus.m0_lock = lock; bus.m0_addr = addr;
    bus.m0_wdata = wdata; bus.m0_byteen = be;
  endtask

  task automatic set_m1(input logic req, input logic lock, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    bus.m1_req = req; bus.m1_lock = lock; bus.m1_addr = addr;
    bus.m1_wdata = wdata; bus.m1_byteen = be;
  endtask

  task automatic exp_iss(input logic mst, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
    iss_t e;
    e.cyc = cyc; e.mst = mst; e.addr = addr; e.wdata = wdata; e.be = be;
    iss_q.push_back(e);
  endtask

  task automatic exp_rd(input logic mst, input logic [31:0] data);
    rd_t e;
    e.cyc = cyc + RD_LAT; e.mst = mst; e.data = data;
    rd_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_flags"}, 64'({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.mem_en}), 64'h0);
    chk({name, "_data"}, 64'(bus.m0_rdata | bus.m1_rdata | bus.mem_addr | bus.mem_wdata |
                             {28'h0, bus.mem_byteen}), 64'h0);
  endtask

  // Monitor: pops expected issues/returns whenever the DUT presents one.
  always @(negedge clk) begin
    if (reset) begin
      iss_t e;
      rd_t  r;
      chk("gnt_invariant", 64'({bus.m0_gnt & ~bus.m0_req, bus.m1_gnt & ~bus.m1_req,
                                bus.m0_gnt & bus.m1_gnt, bus.m0_rvalid & bus.m1_rvalid,
                                bus.mem_en ^ (bus.m0_gnt | bus.m1_gnt)}), 64'h0);
      chk("idle_zero", 64'((bus.mem_en ? 32'h0 : (bus.mem_addr | bus.mem_wdata | {28'h0, bus.mem_byteen})) |
                           (bus.m0_rvalid ? 32'h0 : bus.m0_rdata) |
                           (bus.m1_rvalid ? 32'h0 : bus.m1_rdata)), 64'h0);
      if (bus.mem_en) begin
        if (iss_q.size() > 0) e = iss_q.pop_front();
        else begin e.cyc = -1; e.mst = 1'b0; e.addr = '0; e.wdata = '0; e.be = '0; end
        chk("iss_cycle", 64'(cyc), 64'(e.cyc));
        chk("iss_master", 64'({bus.m1_gnt, bus.m0_gnt}), e.mst ? 64'h2 : 64'h1);
        chk("iss_addr", 64'(bus.mem_addr), 64'(e.addr));
        chk("iss_wdata_be", 64'({bus.mem_wdata, bus.mem_byteen}), 64'({e.wdata, e.be}));
      end
      if (bus.m0_rvalid | bus.m1_rvalid) begin
        if (rd_q.size() > 0) r = rd_q.pop_front();
        else begin r.cyc = -1; r.mst = 1'b0; r.data = '0; end
        chk("rd_cycle", 64'(cyc), 64'(r.cyc));
        chk("rd_master", 64'({bus.m1_rvalid, bus.m0_rvalid}), r.mst ? 64'h2 : 64'h1);
        chk("rd_data", 64'(r.mst ? bus.m1_rdata : bus.m0_rdata), 64'(r.data));
      end
    end
  end

  initial begin
    set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    bus.mem_rdata = 32'h0;
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk_all_zero("reset_state");
`ifdef DM_ARB_STATS_EN
    chk("stat_reset", 64'({stat_gnt0, stat_gnt1}) | 64'(stat_stall1), 64'h0);
`endif

    // Contention from reset: m0 writes, m1 reads, grants alternate starting with m0.
    for (int i = 0; i < 6 + RD_LAT; i++) begin
      tick();
      bus.mem_rdata = 32'hC0DE_0000 + 32'(i);
      if (i < 6) begin
        set_m0(1'b1, 1'b0, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF);
        set_m1(1'b1, 1'b0, 32'h200 + 32'(i * 4), 32'h0, 4'h0);
        if (i % 2 == 0) exp_iss(MST0, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF);
        else begin
          exp_iss(MST1, 32'h200 + 32'(i * 4), 32'h0, 4'h0);
          exp_rd(MST1, 32'hC0DE_0000 + 32'(i + RD_LAT));
        end
      end else begin
        set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
    end
`ifdef DM_ARB_STATS_EN
    chk("stat_gnt0", 64'(stat_gnt0), 64'd3);
    chk("stat_gnt1", 64'(stat_gnt1), 64'd3);
    chk("stat_stall1", 64'(stat_stall1), 64'd3);
`endif

    // Single-master read.
    tick();
    bus.mem_rdata = 32'hDEAD_BEEF;
    set_m0(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    exp_iss(MST0, 32'h0000_0010, 32'h0, 4'h0);
    exp_rd(MST0, 32'hDEAD_BEEF);
    tick();
    set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) tick();

    // Lock: m0 wins the first contended cycle, then m1 holds the bus for three writes.
    tick();
    set_m0(1'b1, 1'b0, 32'h300, 32'hB0, 4'hF);
    set_m1(1'b1, 1'b1, 32'h0000_7F00, 32'h11, 4'hF);
    exp_iss(MST0, 32'h300, 32'hB0, 4'hF);
    tick();
    set_m0(1'b1, 1'b0, 32'h304, 32'hB1, 4'hF);
    exp_iss(MST1, 32'h0000_7F00, 32'h11, 4'hF);
    tick();
    set_m1(1'b1, 1'b1, 32'h0000_7F04, 32'h22, 4'hF);
    exp_iss(MST1, 32'h0000_7F04, 32'h22, 4'hF);
    tick();
    set_m1(1'b1, 1'b0, 32'h0000_7F08, 32'h33, 4'hF);
    exp_iss(MST1, 32'h0000_7F08, 32'h33, 4'hF);
    tick();
    set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    exp_iss(MST0, 32'h304, 32'hB1, 4'hF);
    tick();
    set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Forced hand-over: eight locked m0 grants, one empty cycle, then m1.
    bus.mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 10 + RD_LAT; i++) begin
      tick();
      if (i < 10) begin
        set_m0(1'b1, 1'b1, 32'h400 + 32'((i < 8 ? i : 8) * 4), 32'hC0 + 32'(i < 8 ? i : 8), 4'hF);
        set_m1(1'b1, 1'b0, 32'h500, 32'h0, 4'h0);
        if (i < 8) exp_iss(MST0, 32'h400 + 32'(i * 4), 32'hC0 + 32'(i), 4'hF);
        if (i == 9) begin
          exp_iss(MST1, 32'h500, 32'h0, 4'h0);
          exp_rd(MST1, 32'h1234_5678);
        end
      end else begin
        set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
    end
    tick();

    // Async reset with a read return in flight.
    tick();
    bus.mem_rdata = 32'hFEED_F00D;
    set_m0(1'b1, 1'b0, 32'h600, 32'h0, 4'h0);
    exp_iss(MST0, 32'h600, 32'h0, 4'h0);
    tick();
    set_m1(1'b1, 1'b0, 32'h700, 32'h0, 4'h0);
    reset = 1'b0;
    #1;
    chk_all_zero("in_reset");
    repeat (2) tick();
    reset = 1'b1;
    exp_iss(MST0, 32'h600, 32'h0, 4'h0);
    exp_rd(MST0, 32'hFEED_F00D);
    tick();
    set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) tick();

    chk("iss_left", 64'(iss_q.size()), 64'h0);
    chk("rd_left", 64'(rd_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
